// File: rtl/gemini_wb_pkg.sv
// Shared types and helpers for the writeback port arbiter and its pending FIFO.
package gemini_wb_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;

    typedef struct packed {
        logic                  vld;
        logic [REG_ADDR_W-1:0] addr;
        logic [DATA_W-1:0]     data;
    } wb_pend_entry_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/wb_pend_fifo.sv
// Pending-result FIFO for long-latency writebacks; entries can be squashed
// in place by address so a younger pipeline write wins on WAW.
module wb_pend_fifo
    import gemini_wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  push_vld,
    input  logic [REG_ADDR_W-1:0] push_addr,
    input  logic [DATA_W-1:0]     push_data,
    input  logic                  pop,
    input  logic                  squash_en,
    input  logic [REG_ADDR_W-1:0] squash_addr,
    output logic                  head_vld,
    output logic [REG_ADDR_W-1:0] head_addr,
    output logic [DATA_W-1:0]     head_data,
    output logic                  full,
    output logic                  empty,
    output logic [clog2(DEPTH):0] count
);

    localparam int          AW       = clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [DEPTH-1:0]      vld_q, vld_d;
    logic [REG_ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0]     data_q [DEPTH];
    logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
    logic [AW:0]           count_q;
    logic                  push_ok, pop_ok;

    assign full     = (count_q == FULL_CNT);
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign push_ok  = push & ~full;
    assign pop_ok   = pop & ~empty;
    assign head_vld  = vld_q[rd_ptr_q];
    assign head_addr = addr_q[rd_ptr_q];
    assign head_data = data_q[rd_ptr_q];

    // Squash compares every slot; stale slots are harmless, and the pushed
    // slot is written last so its own validity is decided by the caller.
    always_comb begin
        vld_d = vld_q;
        if (squash_en) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (addr_q[i] == squash_addr) vld_d[i] = 1'b0;
            end
        end
        if (push_ok) vld_d[wr_ptr_q] = push_vld;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            vld_q <= vld_d;
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            addr_q[wr_ptr_q] <= push_addr;
            data_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the single regfile write port between the pipeline writeback
// stream (priority) and buffered long-latency results, with anti-starvation stall.
module wb_port_arbiter
    import gemini_wb_pkg::*;
#(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  p_valid,
    input  logic [REG_ADDR_W-1:0] p_addr,
    input  logic [DATA_W-1:0]     p_data,
    input  logic                  lu_valid,
    output logic                  lu_ready,
    input  logic [REG_ADDR_W-1:0] lu_addr,
    input  logic [DATA_W-1:0]     lu_data,
    output logic                  pipe_stall,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0]     rf_wdata,
    output logic [clog2(DEPTH):0] pend_cnt
);

    localparam int          SW   = clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

    wb_pend_entry_t        push_e, head_e;
    logic                  full, empty;
    logic                  p_grant, p_wr, pop, push, head_squash;
    logic                  pipe_stall_q, pipe_stall_d;
    logic                  rf_we_q, rf_we_d;
    logic [REG_ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
    logic [DATA_W-1:0]     rf_wdata_q, rf_wdata_d;
    logic [SW-1:0]         starve_q, starve_d;

    assign lu_ready = ~full & ~rst;

    wb_pend_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push        (push),
        .push_vld    (push_e.vld),
        .push_addr   (push_e.addr),
        .push_data   (push_e.data),
        .pop         (pop),
        .squash_en   (p_wr),
        .squash_addr (p_addr),
        .head_vld    (head_e.vld),
        .head_addr   (head_e.addr),
        .head_data   (head_e.data),
        .full        (full),
        .empty       (empty),
        .count       (pend_cnt)
    );

    always_comb begin
        p_grant      = p_valid & ~pipe_stall_q;
        p_wr         = p_grant & (p_addr != '0);
        pop          = ~p_grant & ~empty;
        push         = lu_valid & lu_ready & (lu_addr != '0);
        // A result arriving alongside a pipeline write to the same register is older.
        push_e.vld   = ~(p_wr & (lu_addr == p_addr));
        push_e.addr  = lu_addr;
        push_e.data  = lu_data;
        head_squash  = p_wr & (head_e.addr == p_addr);
        rf_we_d      = 1'b0;
        rf_waddr_d   = rf_waddr_q;
        rf_wdata_d   = rf_wdata_q;
        starve_d     = '0;

        if (p_wr) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = p_addr;
            rf_wdata_d = p_data;
        end else if (pop & head_e.vld) begin
            rf_we_d    = 1'b1;
            rf_waddr_d = head_e.addr;
            rf_wdata_d = head_e.data;
        end

        if (empty | pop | ~head_e.vld | head_squash) starve_d = '0;
        else if (starve_q != SMAX)                   starve_d = starve_q + 1'b1;
        else                                         starve_d = starve_q;

        pipe_stall_d = ~pipe_stall_q & (starve_d == SMAX);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pipe_stall_q <= 1'b0;
            rf_we_q      <= 1'b0;
            rf_waddr_q   <= '0;
            rf_wdata_q   <= '0;
            starve_q     <= '0;
        end else begin
            pipe_stall_q <= pipe_stall_d;
            rf_we_q      <= rf_we_d;
            rf_waddr_q   <= rf_waddr_d;
            rf_wdata_q   <= rf_wdata_d;
            starve_q     <= starve_d;
        end
    end

    assign pipe_stall = pipe_stall_q;
    assign rf_we      = rf_we_q;
    assign rf_waddr   = rf_waddr_q;
    assign rf_wdata   = rf_wdata_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: queue-based reference model checked every
// cycle, plus literal expectations at the interesting cycles.
module tb_wb_port_arbiter;

    localparam int DEPTH      = 2;
    localparam int STARVE_MAX = 4;
    localparam int CW         = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          p_valid = 1'b0;
    logic [4:0]    p_addr = '0;
    logic [31:0]   p_data = '0;
    logic          lu_valid = 1'b0;
    logic          lu_ready;
    logic [4:0]    lu_addr = '0;
    logic [31:0]   lu_data = '0;
    logic          pipe_stall, rf_we;
    logic [4:0]    rf_waddr;
    logic [31:0]   rf_wdata;
    logic [CW-1:0] pend_cnt;

    wb_port_arbiter #(.DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst(rst),
        .p_valid(p_valid), .p_addr(p_addr), .p_data(p_data),
        .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_addr(lu_addr), .lu_data(lu_data),
        .pipe_stall(pipe_stall), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .pend_cnt(pend_cnt)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_on = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: pending results as a queue, port ownership from the rules.
    typedef struct { logic vld; logic [4:0] addr; logic [31:0] data; } ment_t;
    ment_t       mq[$];
    logic        m_we, m_stall;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;
    int          m_streak;

    task automatic model_reset();
        mq.delete();
        m_we = 0; m_stall = 0; m_waddr = 0; m_wdata = 0; m_streak = 0;
    endtask

    task automatic model_step();
        bit full, empty, grant, popped, denied;
        ment_t e;
        if (rst) begin
            model_reset();
            return;
        end
        full   = (mq.size() == DEPTH);
        empty  = (mq.size() == 0);
        grant  = p_valid && !m_stall;
        popped = 0;
        if (grant) begin
            m_we = (p_addr != 0);
            if (p_addr != 0) begin
                m_waddr = p_addr;
                m_wdata = p_data;
                foreach (mq[i]) if (mq[i].addr == p_addr) mq[i].vld = 1'b0;
            end
        end else if (!empty) begin
            e = mq.pop_front();
            popped = 1;
            m_we = e.vld;
            if (e.vld) begin
                m_waddr = e.addr;
                m_wdata = e.data;
            end
        end else begin
            m_we = 0;
        end
        denied = !popped && !empty && mq[0].vld;
        if (lu_valid && !full && lu_addr != 0) begin
            e.vld  = !(grant && p_addr == lu_addr);
            e.addr = lu_addr;
            e.data = lu_data;
            mq.push_back(e);
        end
        if (denied) m_streak = (m_streak < STARVE_MAX) ? m_streak + 1 : STARVE_MAX;
        else        m_streak = 0;
        m_stall = !m_stall && (m_streak == STARVE_MAX);
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            check("rf_we",      rf_we,      m_we);
            check("rf_waddr",   rf_waddr,   m_waddr);
            check("rf_wdata",   rf_wdata,   m_wdata);
            check("pipe_stall", pipe_stall, m_stall);
            check("pend_cnt",   pend_cnt,   mq.size());
            check("lu_ready",   lu_ready,   (!rst && mq.size() < DEPTH));
        end
    end

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic drive(input bit pv, input int pa, input int pd, input bit lv, input int la, input int ld);
        p_valid = pv; p_addr = 5'(pa); p_data = 32'(pd);
        lu_valid = lv; lu_addr = 5'(la); lu_data = 32'(ld);
    endtask

    task automatic idle(input int n);
        drive(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < n; i++) tick();
    endtask

    int  a, stalls;
    bit  st;

    initial begin
        model_reset();
        tick();
        tick();
        rst = 1'b0;
        chk_on = 1'b1;
        check("reset rf_we", rf_we, 0);
        check("reset pend_cnt", pend_cnt, 0);
        check("reset pipe_stall", pipe_stall, 0);
        idle(1);

        // Single LU result into an empty FIFO with the pipeline idle.
        drive(0, 0, 0, 1, 5, 32'hDEADBEEF);
        check("t1 lu_ready", lu_ready, 1);
        tick();
        drive(0, 0, 0, 0, 0, 0);
        check("t1 pend after push", pend_cnt, 1);
        check("t1 no bypass", rf_we, 0);
        tick();
        check("t1 rf_we", rf_we, 1);
        check("t1 rf_waddr", rf_waddr, 5);
        check("t1 rf_wdata", rf_wdata, 32'hDEADBEEF);
        check("t1 pend drained", pend_cnt, 0);
        idle(2);

        // Starvation: continuous pipeline stream, one LU result.
        a = 1; stalls = 0;
        for (int k = 0; k < 8; k++) begin
            drive(1, a, 32'h100 + a, k == 0, 7, 32'h77);
            st = pipe_stall;
            tick();
            if (pipe_stall) stalls++;
            if (k == 3) check("t2 no early stall", pipe_stall, 0);
            if (k == 4) check("t2 stall asserted", pipe_stall, 1);
            if (k == 5) begin
                check("t2 stall drops", pipe_stall, 0);
                check("t2 r7 we", rf_we, 1);
                check("t2 r7 addr", rf_waddr, 7);
                check("t2 r7 data", rf_wdata, 32'h77);
            end
            if (k == 6) begin
                check("t2 held addr", rf_waddr, 6);
                check("t2 held data", rf_wdata, 32'h106);
            end
            if (k == 7) check("t2 next addr", rf_waddr, 7);
            if (!st) a++;
        end
        check("t2 stall cycles", stalls, 1);
        idle(3);

        // WAW squash of a stored entry.
        drive(1, 10, 32'h1010, 1, 3, 32'h11);
        tick();
        drive(1, 3, 32'h22, 0, 0, 0);
        tick();
        check("t3 r3 addr", rf_waddr, 3);
        check("t3 r3 data", rf_wdata, 32'h22);
        drive(0, 0, 0, 0, 0, 0);
        tick();
        check("t3 squashed pop we", rf_we, 0);
        check("t3 data held", rf_wdata, 32'h22);
        check("t3 pend empty", pend_cnt, 0);
        idle(2);

        // Same-cycle push and pipeline write to r9.
        drive(1, 9, 32'hB, 1, 9, 32'hA);
        tick();
        check("t4 r9 data", rf_wdata, 32'hB);
        check("t4 pend", pend_cnt, 1);
        drive(0, 0, 0, 0, 0, 0);
        tick();
        check("t4 squashed pop we", rf_we, 0);
        check("t4 data held", rf_wdata, 32'hB);
        idle(2);

        // Fill the FIFO while the pipeline is busy.
        for (int k = 0; k < 7; k++) begin
            drive(1, 20, 32'h2020, 1, (k == 0) ? 11 : (k == 1) ? 12 : 13, 32'hC00 + k);
            tick();
            if (k == 1) check("t5 full lu_ready", lu_ready, 0);
            if (k == 4) check("t5 still full", lu_ready, 0);
            if (k == 5) begin
                check("t5 first pop addr", rf_waddr, 11);
                check("t5 pend after pop", pend_cnt, 1);
                check("t5 ready after pop", lu_ready, 1);
            end
            if (k == 6) check("t5 held push taken", pend_cnt, 2);
        end
        idle(4);

        // r0 traffic is dropped on both sides.
        drive(1, 0, 32'h1234, 1, 0, 32'hBAD);
        tick();
        check("t6 r0 we", rf_we, 0);
        check("t6 r0 pend", pend_cnt, 0);
        idle(2);

        // Reset with two entries pending.
        drive(1, 21, 32'h2121, 1, 14, 32'hE);
        tick();
        drive(1, 21, 32'h2121, 1, 15, 32'hF);
        tick();
        check("t6 pend before rst", pend_cnt, 2);
        rst = 1'b1;
        model_reset();
        #1;
        check("t6 rst pend", pend_cnt, 0);
        check("t6 rst lu_ready", lu_ready, 0);
        drive(0, 0, 0, 0, 0, 0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t6 no write after rst", rf_we, 0);
        end
        check("t6 pend after rst", pend_cnt, 0);
        idle(1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between the in-order pipeline writeback stream and one long-latency result source (divider / load-miss return).
- The long-latency source uses a valid/ready handshake. Its results are held in a small pending FIFO.
- The pipeline has priority. The FIFO drains in idle slots; a starvation counter forces a one-cycle pipeline stall so the FIFO cannot be blocked indefinitely.
- Pipeline writes squash older pending writes to the same register (WAW), and writes to r0 are dropped.
- Sits between the writeback-select stage and the regfile.

Parameters:
- DEPTH, 2, pending FIFO entries (power of two, >=2).
- STARVE_MAX, 4, consecutive denied cycles of a valid FIFO head before pipe_stall is forced.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- p_valid  in  1  pipeline writeback request
- p_addr  in  5  pipeline destination register
- p_data  in  32  pipeline write data
- lu_valid  in  1  long-latency result valid
- lu_ready  out  1  FIFO can accept
- lu_addr  in  5  long-latency destination register
- lu_data  in  32  long-latency result data
- pipe_stall  out  1  pipeline must hold its current writeback (registered)
- rf_we  out  1  regfile write enable (registered)
- rf_waddr  out  5  regfile write address (registered)
- rf_wdata  out  32  regfile write data (registered)
- pend_cnt  out  log2(DEPTH)+1  occupied FIFO slots, valid or squashed (debug)

Behaviour:
- Clocking and reset:
  - Single clock. Reset is asynchronous and active-high; names are clk/rst.
  - Reset clears rf_we, rf_waddr, rf_wdata, pipe_stall, pend_cnt, starve_cnt, all FIFO valid bits and the pointers.
  - lu_ready = ~full & ~rst. Reset mid-operation discards all pending entries with no write.
- FIFO entry is {vld, addr[4:0], data[31:0]}. Push when lu_valid & lu_ready.
  - lu_addr==0: the handshake completes, nothing is stored.
  - Push and pop may occur in the same cycle. There is no push when full.
- Slot selection, evaluated each cycle:
  - p_grant = p_valid & ~pipe_stall.
  - If p_grant: write the pipeline value, unless p_addr==0 (slot consumed, rf_we=0 next cycle).
  - Else if FIFO non-empty: pop the head. If head.vld, write it; if squashed, pop with no write.
  - At most one pop per cycle.
- Latency:
  - Granted request appears on rf_* exactly 1 cycle later.
  - An LU result accepted at cycle t is written at t+1 at the earliest, i.e. accepted into an empty FIFO with the pipeline idle. There is no same-cycle bypass.
- WAW squash (applies when p_grant with p_addr!=0):
  - Clears vld on every stored entry with addr==p_addr.
  - An LU entry pushed in that same cycle with lu_addr==p_addr is treated as older and stored with vld=0.
- Starvation control:
  - starve_cnt increments each cycle the head is valid and not popped, saturating at STARVE_MAX. It clears on any pop, and when the FIFO is empty or the head is squashed.
  - When starve_cnt reaches STARVE_MAX, pipe_stall=1 in the next cycle, for exactly one cycle. The head is popped in that cycle.
  - pipe_stall never asserts on consecutive cycles.
- The pipeline must hold p_valid/p_addr/p_data stable while pipe_stall=1. The arbiter ignores the pipeline request in that cycle.
- rf_we=0 in any cycle with no granted valid write. rf_waddr/rf_wdata hold their last value when rf_we=0.

Decomposition:
- Shared package gemini_wb_pkg contains:
  - REG_ADDR_W=5, DATA_W=32.
  - Typedef wb_pend_entry_t {vld, addr, data}.
  - Function clog2 for pend_cnt width.
- Sub-module wb_pend_fifo contains:
  - Storage, pointers, full/empty and count.
  - Parallel address-compare squash input (squash_en, squash_addr).
- The top level holds slot selection, the starvation counter and the output registers.

Test Plan:
- Reset release, pipeline idle, push {r5,0xDEAD_BEEF} at cycle 2 -> rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF at cycle 3; lu_ready=1 throughout; pend_cnt returns to 0.
- p_valid constant with r1..rN, one LU push of {r7,0x77}, STARVE_MAX=4 -> r7 written in the cycle after pipe_stall=1. pipe_stall is high exactly one cycle. The held pipeline write is issued the cycle after the stall, with no loss or duplication.
- Push {r3,0x11}, then pipeline write {r3,0x22} before drain -> only 0x22 written to r3. The squashed entry pops later with rf_we=0.
- Same-cycle push {r9,0xA} and pipeline write {r9,0xB} -> only 0xB reaches r9.
- Fill FIFO (DEPTH=2) while pipeline busy -> lu_ready=0; a held lu_valid is accepted the cycle after the first pop.
- lu_addr=0 push and p_addr=0 request -> no rf_we asserted, pend_cnt unchanged. Asserting rst with 2 entries pending -> FIFO empty and no writes after release.
